sudoku_board_scanner: RTL and testbench
=======================================

# sudoku_board_scanner

Read-side companion to the Sudoku datapath. It snapshots the datapath's 16 user-board cells, the per-cell `fill_flag` and `solved`, then streams them as a fixed 19-byte frame over a valid/ready byte interface toward the display/host link. It sits between the `dp` outputs and the output serializer/pad logic, and it never writes to the datapath.

## Interface
Parameters:
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clka`  input  1  system clock; all state updates on the rising edge.
- `restart_n`  input  1  reset, asynchronous, active-low.
- `scan_req`  input  1  request one frame; single-cycle pulse or level.
- `user_board_0` … `user_board_15`  input  3 each  cell values from `dp`.
- `fill_flag`  input  16  bit i set means cell i was filled by the user.
- `solved`  input  1  board solved status from `dp`.
- `out_data`  output  8  frame byte.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts the byte.
- `busy`  output  1  a frame is in progress.
- `frame_done`  output  1  one-cycle pulse when the checksum byte is accepted.

## Operation
- States: IDLE, HDR, CELL, STAT, CSUM.
- IDLE:
  - On `scan_req`=1, snapshot all 16 cells, `fill_flag` and `solved` into internal registers.
  - Clear the checksum and the cell index, then go to HDR.
- Frame byte order:
  - HDR sends `HEADER`.
  - CELL sends 16 bytes, i=0..15. Each byte is {fill_flag[i], i[3:0], cell_i[2:0]}.
  - STAT sends {solved, 7'b0}.
  - CSUM sends the XOR of all 18 preceding bytes.
- A byte advances only on a handshake (`out_valid && out_ready`).
  - The checksum accumulates on each handshake.
  - The cell index increments on each CELL handshake and wraps 15→0 on leaving CELL.
- Frames are built from the snapshot only. Input changes during a frame do not affect it.
- `scan_req` while `busy`:
  - Sets a one-deep pending flag. Further requests are merged into it.
  - On the CSUM handshake with pending set, clear pending, take a new snapshot in the same edge, and go straight to HDR (no IDLE cycle).
  - Otherwise go to IDLE.
- `scan_req` in the same cycle as the CSUM handshake counts as pending.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `frame_done`=0. Snapshot, checksum, index and pending are all 0. State is IDLE.
- Latency: `scan_req` sampled at edge N puts the header on `out_data` with `out_valid`=1 after edge N.
- With `out_ready` held high, one byte transfers per cycle, so a frame takes 19 cycles. Back-to-back frames have no gap.
- `out_valid` stays high from HDR through CSUM.
- While `out_valid && !out_ready`, `out_data` is held stable.
- `busy` equals (state != IDLE).
- `frame_done` is high for exactly the cycle after the CSUM handshake edge.
- Reset asserted mid-frame: `out_valid` and `busy` drop immediately (asynchronously). The frame is abandoned, pending is cleared, and there is no partial resume.

## Configuration
- `SCAN_AUTO_EN` defined:
  - Keep a copy of the last transmitted snapshot.
  - In IDLE, start a frame automatically whenever the current cells, `fill_flag` or `solved` differ from that copy.
  - `scan_req` still works as well.
  - After reset the copy is all-zero, so a nonzero board triggers a frame.
- `SCAN_AUTO_EN` not defined: frames start only from `scan_req` or a pending request, and the copy registers are not instantiated.

## Test plan
- Reset, then all inputs 0 and `scan_req` pulsed with `out_ready`=1 → 19 bytes: A5, 00, 08, 10, …, 78, 00, A5. `frame_done` pulses once and `busy` is high for 19 cycles.
- `solved`=1 with everything else 0, scan → status byte 80, checksum 25.
- `user_board_5`=3'd4 and `fill_flag`=16'h0020, scan → cell byte 5 = AC, checksum = A5^AC^28 = 21.
- `out_ready` toggled 1,0,0,1 during CELL → no byte lost or duplicated and `out_data` stable while stalled. Changing `user_board_0` mid-frame leaves the frame unchanged.
- `scan_req` pulsed at byte 7, and again at the CSUM accept cycle → exactly one extra frame, starting the cycle after the first CSUM with no IDLE gap.
- `restart_n` low at byte 10 → `out_valid`=0 immediately. After release plus `scan_req`, a full correct frame is sent.
- With `SCAN_AUTO_EN` only: changing `user_board_2` to 1 while idle → a frame starts without `scan_req`. No further frame is sent while the inputs stay unchanged.

Source files
------------

// File: rtl/sudoku_board_scanner.sv
// Snapshots the 16 user-board cells, fill flags and solved bit, then streams a
// 19-byte frame (header, 16 cells, status, XOR checksum) over valid/ready.
// Define SCAN_AUTO_EN to also start frames automatically when the board changes.
module sudoku_board_scanner #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        scan_req,
    input  logic [2:0]  user_board_0,
    input  logic [2:0]  user_board_1,
    input  logic [2:0]  user_board_2,
    input  logic [2:0]  user_board_3,
    input  logic [2:0]  user_board_4,
    input  logic [2:0]  user_board_5,
    input  logic [2:0]  user_board_6,
    input  logic [2:0]  user_board_7,
    input  logic [2:0]  user_board_8,
    input  logic [2:0]  user_board_9,
    input  logic [2:0]  user_board_10,
    input  logic [2:0]  user_board_11,
    input  logic [2:0]  user_board_12,
    input  logic [2:0]  user_board_13,
    input  logic [2:0]  user_board_14,
    input  logic [2:0]  user_board_15,
    input  logic [15:0] fill_flag,
    input  logic        solved,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_CELL = 3'd2;
    localparam logic [2:0] S_STAT = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;

    logic [2:0]       state;
    logic [15:0][2:0] cur_cell;
    logic [15:0][2:0] snap_cell;
    logic [15:0]      snap_fill;
    logic             snap_solved;
    logic [7:0]       csum;
    logic [3:0]       idx;
    logic             pending;
    logic             hs;
    logic             last_hs;
    logic             auto_start;
    logic             start_idle;
    logic             take_snap;

    assign cur_cell = {user_board_15, user_board_14, user_board_13, user_board_12,
                       user_board_11, user_board_10, user_board_9,  user_board_8,
                       user_board_7,  user_board_6,  user_board_5,  user_board_4,
                       user_board_3,  user_board_2,  user_board_1,  user_board_0};

    // Valid/busy decode straight from state so an async reset drops them at once.
    assign out_valid = (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign hs        = out_valid && out_ready;
    assign last_hs   = (state == S_CSUM) && hs;

`ifdef SCAN_AUTO_EN
    logic [15:0][2:0] copy_cell;
    logic [15:0]      copy_fill;
    logic             copy_solved;

    assign auto_start = ({cur_cell, fill_flag, solved} != {copy_cell, copy_fill, copy_solved});

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            copy_cell   <= '0;
            copy_fill   <= '0;
            copy_solved <= 1'b0;
        end else if (last_hs) begin
            copy_cell   <= snap_cell;
            copy_fill   <= snap_fill;
            copy_solved <= snap_solved;
        end
    end
`else
    assign auto_start = 1'b0;
`endif

    assign start_idle = (state == S_IDLE) && (scan_req || auto_start);
    // A request arriving on the checksum accept restarts the frame with no idle cycle.
    assign take_snap  = start_idle || (last_hs && (pending || scan_req));

    always_comb begin
        out_data = '0;
        case (state)
            S_HDR:   out_data = HEADER;
            S_CELL:  out_data = {snap_fill[idx], idx, snap_cell[idx]};
            S_STAT:  out_data = {snap_solved, 7'b0};
            S_CSUM:  out_data = csum;
            default: out_data = '0;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state       <= S_IDLE;
            snap_cell   <= '0;
            snap_fill   <= '0;
            snap_solved <= 1'b0;
            csum        <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_hs;

            if (take_snap) begin
                snap_cell   <= cur_cell;
                snap_fill   <= fill_flag;
                snap_solved <= solved;
                csum        <= '0;
                idx         <= '0;
            end else if (hs) begin
                csum <= csum ^ out_data;
                if (state == S_CELL)
                    idx <= idx + 4'd1;
            end

            if (last_hs)
                pending <= 1'b0;
            else if (busy && scan_req)
                pending <= 1'b1;

            case (state)
                S_IDLE: if (start_idle) state <= S_HDR;
                S_HDR:  if (hs) state <= S_CELL;
                S_CELL: if (hs && idx == 4'd15) state <= S_STAT;
                S_STAT: if (hs) state <= S_CSUM;
                S_CSUM: if (hs) state <= take_snap ? S_HDR : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_board_scanner.sv
// Randomized bench for sudoku_board_scanner: a frame-level reference model
// predicts every byte, busy/valid and frame_done; directed cases cover the known frames.
module tb_sudoku_board_scanner;

    logic        clka = 1'b0;
    logic        restart_n;
    logic        scan_req;
    logic [2:0]  ub [16];
    logic [15:0] fill_flag;
    logic        solved;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;

    sudoku_board_scanner #(.HEADER(8'hA5)) dut (
        .clka(clka), .restart_n(restart_n), .scan_req(scan_req),
        .user_board_0(ub[0]),   .user_board_1(ub[1]),   .user_board_2(ub[2]),
        .user_board_3(ub[3]),   .user_board_4(ub[4]),   .user_board_5(ub[5]),
        .user_board_6(ub[6]),   .user_board_7(ub[7]),   .user_board_8(ub[8]),
        .user_board_9(ub[9]),   .user_board_10(ub[10]), .user_board_11(ub[11]),
        .user_board_12(ub[12]), .user_board_13(ub[13]), .user_board_14(ub[14]),
        .user_board_15(ub[15]),
        .fill_flag(fill_flag), .solved(solved),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clka = ~clka;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] acc_q[$];
    bit pending_m = 1'b0;
    bit done_exp  = 1'b0;
`ifdef SCAN_AUTO_EN
    logic [64:0] last_sent  = '0;
    logic [64:0] frame_snap = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [64:0] cur_inputs();
        logic [64:0] v = '0;
        for (int i = 0; i < 16; i++) v[17 + 3*i +: 3] = ub[i];
        v[16:1] = fill_flag;
        v[0]    = solved;
        return v;
    endfunction

    // Frame built from the board rules: header, cells, status, running XOR.
    task automatic push_frame();
        logic [7:0] b;
        logic [7:0] x;
        x = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            b = 8'((fill_flag[i] ? 128 : 0) + i * 8 + int'(ub[i]));
            exp_q.push_back(b);
            x = x ^ b;
        end
        b = solved ? 8'h80 : 8'h00;
        exp_q.push_back(b);
        x = x ^ b;
        exp_q.push_back(x);
`ifdef SCAN_AUTO_EN
        frame_snap = cur_inputs();
`endif
    endtask

    // One clock: compare outputs against the model, cross the edge, advance the model.
    task automatic tick();
        bit active;
        bit start;
        bit hs_obs;
        logic [7:0] d_obs;
        active = (exp_q.size() != 0);
        check("valid", {31'b0, out_valid}, {31'b0, active});
        check("busy", {31'b0, busy}, {31'b0, active});
        if (active) check("data", {24'b0, out_data}, {24'b0, exp_q[0]});
        check("frame_done", {31'b0, frame_done}, {31'b0, done_exp});
        if (frame_done) fd_cnt++;
        hs_obs = out_valid && out_ready;
        d_obs  = out_data;
        @(posedge clka);
        done_exp = 1'b0;
        if (!active) begin
            start = scan_req;
`ifdef SCAN_AUTO_EN
            if (cur_inputs() != last_sent) start = 1'b1;
`endif
            if (start) push_frame();
        end else begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    done_exp = 1'b1;
`ifdef SCAN_AUTO_EN
                    last_sent = frame_snap;
`endif
                    if (pending_m || scan_req) begin
                        push_frame();
                        pending_m = 1'b0;
                    end
                end else if (scan_req) pending_m = 1'b1;
            end else if (scan_req) pending_m = 1'b1;
        end
        if (hs_obs) acc_q.push_back(d_obs);
        #1;
    endtask

    task automatic pulse_scan();
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || pending_m); i++) tick();
        check("drain_timeout", {31'b0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 16; i++) ub[i] = 3'd0;
        fill_flag = '0;
        solved    = 1'b0;
    endtask

    initial begin
        restart_n = 1'b0;
        scan_req  = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        #1;
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, frame_done}, 32'd0);
        @(posedge clka); @(posedge clka); #1;
        restart_n = 1'b1;
        tick();

        // All-zero board
        acc_q.delete();
        fd_cnt = 0;
        pulse_scan();
        drain();
        check("zero_len", acc_q.size(), 32'd19);
        check("zero_hdr", {24'b0, acc_q[0]}, 32'hA5);
        check("zero_c0", {24'b0, acc_q[1]}, 32'h00);
        check("zero_c1", {24'b0, acc_q[2]}, 32'h08);
        check("zero_c15", {24'b0, acc_q[16]}, 32'h78);
        check("zero_csum", {24'b0, acc_q[18]}, 32'hA5);
        check("zero_fd", fd_cnt, 32'd1);

        // Solved status byte
        solved = 1'b1;
        acc_q.delete();
        pulse_scan();
        drain();
        check("solved_stat", {24'b0, acc_q[17]}, 32'h80);
        check("solved_csum", {24'b0, acc_q[18]}, 32'h25);

        // Single filled cell
        solved = 1'b0;
        ub[5] = 3'd4;
        fill_flag = 16'h0020;
        acc_q.delete();
        pulse_scan();
        drain();
        check("cell5", {24'b0, acc_q[6]}, 32'hAC);
        check("cell5_csum", {24'b0, acc_q[18]}, 32'h21);

        // Stalls in CELL and an input change mid-frame
        clear_inputs();
        ub[0] = 3'd2;
        acc_q.delete();
        pulse_scan();
        for (int i = 0; i < 50 && acc_q.size() < 3; i++) tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; ub[0] = 3'd7; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        drain();
        check("stall_len", acc_q.size(), 32'd19);
        check("stall_c0", {24'b0, acc_q[1]}, 32'h02);

        // Requests at byte 7 and on the checksum accept merge into one extra frame
        fd_cnt = 0;
        acc_q.delete();
        pulse_scan();
        for (int i = 0; i < 50 && acc_q.size() < 7; i++) tick();
        pulse_scan();
        for (int i = 0; i < 50 && exp_q.size() != 1; i++) tick();
        pulse_scan();
        drain();
        check("pend_fd", fd_cnt, 32'd2);
        check("pend_len", acc_q.size(), 32'd38);

        // Reset mid-frame
        ub[3] = 3'd5;
        pulse_scan();
        for (int i = 0; i < 50 && acc_q.size() < 48; i++) tick();
        #3;
        restart_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        pending_m = 1'b0;
        done_exp  = 1'b0;
`ifdef SCAN_AUTO_EN
        last_sent = '0;
`endif
        @(posedge clka); #1;
        restart_n = 1'b1;
        tick();
        acc_q.delete();
        pulse_scan();
        drain();
        check("postrst_len", acc_q.size(), 32'd19);

`ifdef SCAN_AUTO_EN
        // Change while idle starts a frame on its own, then nothing more
        fd_cnt = 0;
        ub[2] = 3'd1;
        for (int i = 0; i < 60; i++) tick();
        check("auto_fd", fd_cnt, 32'd1);
`endif

        // Random traffic: requests, back-pressure and board changes at any time
        for (int c = 0; c < 3000; c++) begin
            scan_req  = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) ub[$urandom_range(0, 15)] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) fill_flag = 16'($urandom);
            if ($urandom_range(0, 49) == 0) solved = ~solved;
            tick();
        end
        scan_req  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
